gba_fb_writer: RTL

Framebuffer write stage directly downstream of the GPU pixel output. It captures the shaded pixel stream (address plus 18-bit RGB666 data, one `we` pulse per pixel) into a small FIFO. It drains the FIFO to an external framebuffer memory port through a req/ack handshake. When interframe blending is enabled, it performs a read-modify-write that averages the new pixel with the pixel already stored at that address.

---
 rtl/gba_fb_writer_if.sv | 20 ++
 rtl/gba_fb_writer.sv | 103 ++++++++++
 2 files changed

// File: rtl/gba_fb_writer_if.sv
// Framebuffer memory port: request/ack write-or-read channel plus read-data return.
interface gba_fb_writer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [17:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [17:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/gba_fb_writer.sv
// GPU pixel stream -> FIFO -> framebuffer memory, with optional
// read-modify-write averaging against the stored pixel.
module gba_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FB_PIXELS  = 38400
) (
  input  logic                  fclk,
  input  logic                  reset_n,
  input  logic [15:0]           pixel_in_addr,
  input  logic [17:0]           pixel_in_data,
  input  logic                  pixel_in_we,
  input  logic                  blend_en,
  gba_fb_writer_if.master       mem,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_ADDR = 16'(FB_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t      state, state_nxt;
  logic [15:0] fifo_addr [FIFO_DEPTH];
  logic [17:0] fifo_data [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [15:0] cur_addr;
  logic [17:0] cur_data, blend_data;

  // Per-channel average: 7-bit sum, keep the upper six bits, no cross-channel carry.
  function automatic logic [5:0] avg6(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[6:1];
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = pixel_in_we && !full;
  assign pop   = (state == IDLE) && !empty;

  assign blend_data = {avg6(cur_data[17:12], mem.mem_rdata[17:12]),
                       avg6(cur_data[11:6],  mem.mem_rdata[11:6]),
                       avg6(cur_data[5:0],   mem.mem_rdata[5:0])};

  always_ff @(posedge fclk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= pixel_in_addr;
      fifo_data[wr_ptr[AW-1:0]] <= pixel_in_data;
    end
  end

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_addr <= fifo_addr[rd_ptr[AW-1:0]];
        cur_data <= fifo_data[rd_ptr[AW-1:0]];
      end else if (state == RD_WAIT && mem.mem_rvalid) begin
        cur_data <= blend_data;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (pixel_in_we && full)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
      frame_done <= (state == WR_REQ) && mem.mem_ack && (cur_addr == LAST_ADDR);
    end
  end

  // blend_en is consumed at pop time only, so it selects the path out of IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty)          state_nxt = blend_en ? RD_REQ : WR_REQ;
      RD_REQ:  if (mem.mem_ack)     state_nxt = RD_WAIT;
      RD_WAIT: if (mem.mem_rvalid)  state_nxt = WR_REQ;
      WR_REQ:  if (mem.mem_ack)     state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  assign mem.mem_req   = (state == RD_REQ) || (state == WR_REQ);
  assign mem.mem_we    = (state == WR_REQ);
  assign mem.mem_addr  = cur_addr;
  assign mem.mem_wdata = cur_data;
  assign busy          = !empty || (state != IDLE);

endmodule
